// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller slice.
//   REG_W_DEF    : default register-address width
//   LOAD_LAT_DEF : default bubble count per load-use hazard
//   CNT_W        : width of the stall counter (covers LOAD_LAT up to 3)
//   state_t      : controller FSM encoding (RUN / STALL)
//   stall_cnt_init : counter preload when entering STALL
package fwd_hazard_ctrl_pkg;

  localparam int REG_W_DEF    = 3;
  localparam int LOAD_LAT_DEF = 1;
  localparam int CNT_W        = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // The hazard-detect cycle already issues the first bubble, so STALL only
  // has to cover the remaining LOAD_LAT-1 cycles; the counter counts down
  // to zero inclusive, hence the preload of LOAD_LAT-2.
  function automatic logic [CNT_W-1:0] stall_cnt_init(input int load_lat);
    if (load_lat > 1) begin
      return CNT_W'(load_lat - 2);
    end
    return '0;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the ID-stage instruction source and the forwarding /
// hazard controller.
//   ID instruction : id_valid, id_rs_a/id_use_a, id_rs_b/id_use_b,
//                    id_rd/id_wr, id_is_load, id_is_store
//   Pipe control   : flush (kill ID instr), mem_busy (freeze pipe)
//   Controller out : stall, bubble, fwd_one_a/two_a, fwd_one_b/two_b,
//                    mw_one/mw_two, dbg_state, dbg_cnt
// Handshake: there is no valid/ready pair. id_valid qualifies the ID fields
// in the cycle they are presented; while stall=1 the source must hold the
// same instruction. mem_busy=1 freezes every controller register; the source
// holds flush for as long as mem_busy is high.
interface fwd_hazard_ctrl_if #(
  parameter int REG_W = fwd_hazard_ctrl_pkg::REG_W_DEF
);
  import fwd_hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs_a;
  logic             id_use_a;
  logic [REG_W-1:0] id_rs_b;
  logic             id_use_b;
  logic [REG_W-1:0] id_rd;
  logic             id_wr;
  logic             id_is_load;
  logic             id_is_store;
  logic             flush;
  logic             mem_busy;

  logic             stall;
  logic             bubble;
  logic             fwd_one_a;
  logic             fwd_two_a;
  logic             fwd_one_b;
  logic             fwd_two_b;
  logic             mw_one;
  logic             mw_two;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b, id_rd, id_wr,
           id_is_load, id_is_store, flush, mem_busy,
    input  stall, bubble, fwd_one_a, fwd_two_a, fwd_one_b, fwd_two_b,
           mw_one, mw_two, dbg_state, dbg_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_use_a, id_rs_b, id_use_b, id_rd, id_wr,
           id_is_load, id_is_store, flush, mem_busy,
    output stall, bubble, fwd_one_a, fwd_two_a, fwd_one_b, fwd_two_b,
           mw_one, mw_two, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// Combinational source/destination comparator.
//   r, used        : source register address and "source is read" flag
//   e_valid, e_wr  : shadow entry holds a real instr that writes its rd
//   e_rd           : shadow entry destination register
//   match          : the source needs the entry's result
// With ZERO_REG set, register 0 never matches (hardwired zero).
module fwd_match #(
  parameter int REG_W    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_W-1:0] r,
  input  logic             used,
  input  logic             e_valid,
  input  logic             e_wr,
  input  logic [REG_W-1:0] e_rd,
  output logic             match
);

  logic r_is_zero;

  assign r_is_zero = ZERO_REG && (r == '0);
  assign match     = e_valid & e_wr & used & (r == e_rd) & ~r_is_zero;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 16-bit datapath, in ID.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of fwd_hazard_ctrl_if (ID instr in, control out)
// Keeps a two-deep shadow of {valid, rd, wr, load} for the instrs in EX and
// MEM, registers the forwarding selects for the instr entering EX, and
// stalls / bubbles LOAD_LAT cycles on a load-use hazard.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  // Shadow pipe. The MEM entry's load flag is never consulted, so only the
  // EX entry keeps one.
  logic             ex_valid, ex_wr, ex_load;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_wr;
  logic [REG_W-1:0] mem_rd;

  logic m_a_ex, m_a_mem, m_b_ex, m_b_mem;
  logic hz, stall, bubble, kill;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic one_a_q, two_a_q, one_b_q, two_b_q, mw_one_q, mw_two_q;
  logic one_a_d, two_a_d, one_b_d, two_b_d, mw_one_d, mw_two_d;
  logic b_one, b_two;

  fwd_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_a_ex (
    .r(bus.id_rs_a), .used(bus.id_use_a), .e_valid(ex_valid), .e_wr(ex_wr),
    .e_rd(ex_rd), .match(m_a_ex));
  fwd_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_a_mem (
    .r(bus.id_rs_a), .used(bus.id_use_a), .e_valid(mem_valid), .e_wr(mem_wr),
    .e_rd(mem_rd), .match(m_a_mem));
  fwd_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_b_ex (
    .r(bus.id_rs_b), .used(bus.id_use_b), .e_valid(ex_valid), .e_wr(ex_wr),
    .e_rd(ex_rd), .match(m_b_ex));
  fwd_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_b_mem (
    .r(bus.id_rs_b), .used(bus.id_use_b), .e_valid(mem_valid), .e_wr(mem_wr),
    .e_rd(mem_rd), .match(m_b_mem));

  // A load in EX only has its result at MEM/WB: a dependent ID instr waits.
  assign hz = bus.id_valid & (m_a_ex | m_b_ex) & ex_load;

  // Select candidates; the EX (younger) producer wins over MEM.
  always_comb begin
    b_one    = bus.id_valid & m_b_ex;
    b_two    = bus.id_valid & m_b_mem & ~m_b_ex;
    one_a_d  = bus.id_valid & m_a_ex;
    two_a_d  = bus.id_valid & m_a_mem & ~m_a_ex;
    // Store data (rs_b) goes through the dedicated MW mux instead.
    one_b_d  = b_one & ~bus.id_is_store;
    two_b_d  = b_two & ~bus.id_is_store;
    mw_one_d = b_one & bus.id_is_store;
    mw_two_d = b_two & bus.id_is_store;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (!bus.mem_busy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz && (LOAD_LAT > 1)) begin
            state_d = ST_STALL;
            cnt_d   = stall_cnt_init(LOAD_LAT);
          end
        end
        ST_STALL: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM: outputs. A busy memory holds the front end but must not push a
  // bubble, since ID/EX is frozen too.
  always_comb begin
    stall  = bus.mem_busy | (~bus.flush & (hz | (state_q == ST_STALL)));
    bubble = stall & ~bus.mem_busy;
    kill   = bubble | bus.flush;
  end

  // Shadow pipe and select registers advance together so the selects are
  // valid exactly while their instr sits in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= '0;
      one_a_q   <= 1'b0;
      two_a_q   <= 1'b0;
      one_b_q   <= 1'b0;
      two_b_q   <= 1'b0;
      mw_one_q  <= 1'b0;
      mw_two_q  <= 1'b0;
    end else if (!bus.mem_busy) begin
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_rd    <= ex_rd;
      ex_valid  <= bus.id_valid & ~kill;
      ex_wr     <= bus.id_wr;
      ex_load   <= bus.id_is_load;
      ex_rd     <= bus.id_rd;
      one_a_q   <= one_a_d  & ~kill;
      two_a_q   <= two_a_d  & ~kill;
      one_b_q   <= one_b_d  & ~kill;
      two_b_q   <= two_b_d  & ~kill;
      mw_one_q  <= mw_one_d & ~kill;
      mw_two_q  <= mw_two_d & ~kill;
    end
  end

  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.fwd_one_a = one_a_q;
  assign bus.fwd_two_a = two_a_q;
  assign bus.fwd_one_b = one_b_q;
  assign bus.fwd_two_b = two_b_q;
  assign bus.mw_one    = mw_one_q;
  assign bus.mw_two    = mw_two_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;

endmodule
